// File: rtl/timer_ctrl_mmss_if.sv
// Bundle of keypad/command inputs and BCD counter-side signals for timer_ctrl_mmss.
// master drives commands and zero flags; slave (the controller) drives presets and status.
interface timer_ctrl_mmss_if;
   logic       tick_1hz;
   logic       digit_valid;
   logic [3:0] key_digit;
   logic       load_btn;
   logic       start;
   logic       stop;
   logic       zero_su, zero_st, zero_mu, zero_mt;
   logic [3:0] data_su, data_st, data_mu, data_mt;
   logic       loadneg;
   logic       en_su;
   logic       running;
   logic       alarm;
   logic       err;

   modport master (
      output tick_1hz, digit_valid, key_digit, load_btn, start, stop,
             zero_su, zero_st, zero_mu, zero_mt,
      input  data_su, data_st, data_mu, data_mt, loadneg, en_su, running, alarm, err
   );

   modport slave (
      input  tick_1hz, digit_valid, key_digit, load_btn, start, stop,
             zero_su, zero_st, zero_mu, zero_mt,
      output data_su, data_st, data_mu, data_mt, loadneg, en_su, running, alarm, err
   );
endinterface

// File: rtl/timer_ctrl_mmss.sv
// MM:SS countdown control: keypad preset buffer, counter load/enable, idle/run/pause/done
// sequencing and alarm hold-off timer.
module timer_ctrl_mmss #(
   parameter int unsigned ALARM_SECS = 10
) (
   input logic           clk,
   input logic           clear,
   timer_ctrl_mmss_if.slave bus
);

   typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

   localparam logic [7:0] ALARM_LD = 8'(ALARM_SECS);

   state_t     state, state_n;
   logic [3:0] su_q, st_q, mu_q, mt_q;
   logic [3:0] su_n, st_n, mu_n, mt_n;
   logic       loadneg_q, loadneg_n;
   logic       running_q, alarm_q;
   logic       err_q, err_n;
   logic       armed_q, armed_n;
   logic [7:0] acnt_q, acnt_n;

   logic zero_all, load_ok, ack;
   logic cmd_load, cmd_stop, cmd_start, cmd_dig;

   // Only the highest-priority command present is considered, even if it ends up ignored.
   assign cmd_load  = bus.load_btn;
   assign cmd_stop  = ~bus.load_btn & bus.stop;
   assign cmd_start = ~bus.load_btn & ~bus.stop & bus.start;
   assign cmd_dig   = ~bus.load_btn & ~bus.stop & ~bus.start & bus.digit_valid;

   assign zero_all = bus.zero_su & bus.zero_st & bus.zero_mu & bus.zero_mt;
   assign load_ok  = (st_q <= 4'd5);
   assign ack      = bus.load_btn | bus.stop | bus.start;

   always_ff @(posedge clk or posedge clear) begin
      if (clear) begin
         state     <= IDLE;
         su_q      <= '0;
         st_q      <= '0;
         mu_q      <= '0;
         mt_q      <= '0;
         loadneg_q <= 1'b1;
         running_q <= 1'b0;
         alarm_q   <= 1'b0;
         err_q     <= 1'b0;
         armed_q   <= 1'b0;
         acnt_q    <= '0;
      end else begin
         state     <= state_n;
         su_q      <= su_n;
         st_q      <= st_n;
         mu_q      <= mu_n;
         mt_q      <= mt_n;
         loadneg_q <= loadneg_n;
         running_q <= (state_n == RUN);
         alarm_q   <= (state_n == DONE);
         err_q     <= err_n;
         armed_q   <= armed_n;
         acnt_q    <= acnt_n;
      end
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE:  if (cmd_start && armed_q && loadneg_q && !zero_all) state_n = RUN;
         RUN:   if (zero_all) state_n = DONE;
                else if (cmd_stop) state_n = PAUSE;
         PAUSE: if (cmd_load && load_ok) state_n = IDLE;
                else if (cmd_start) state_n = RUN;
         DONE:  if (ack || (bus.tick_1hz && acnt_q <= 8'd1)) state_n = IDLE;
      endcase
   end

   always_comb begin
      su_n      = su_q;
      st_n      = st_q;
      mu_n      = mu_q;
      mt_n      = mt_q;
      loadneg_n = 1'b1;
      err_n     = 1'b0;
      armed_n   = armed_q;
      acnt_n    = acnt_q;
      case (state)
         IDLE, PAUSE: begin
            if (cmd_load) begin
               if (load_ok) begin
                  loadneg_n = 1'b0;
                  armed_n   = 1'b1;
               end else begin
                  err_n = 1'b1;
               end
            end else if (state == IDLE && cmd_start && armed_q && zero_all) begin
               err_n = 1'b1;
            end else if (state == IDLE && cmd_dig) begin
               if (bus.key_digit <= 4'd9) begin
                  mt_n    = mu_q;
                  mu_n    = st_q;
                  st_n    = su_q;
                  su_n    = bus.key_digit;
                  armed_n = 1'b0;
               end else begin
                  err_n = 1'b1;
               end
            end
         end
         RUN: if (zero_all) begin
            armed_n = 1'b0;
            acnt_n  = ALARM_LD;
         end
         DONE: if (!ack && bus.tick_1hz) acnt_n = acnt_q - 8'd1;
      endcase
   end

   // Gating on zero_all keeps the counter chain from wrapping 00:00 -> 59:59.
   assign bus.en_su   = bus.tick_1hz & (state == RUN) & ~zero_all;
   assign bus.data_su = su_q;
   assign bus.data_st = st_q;
   assign bus.data_mu = mu_q;
   assign bus.data_mt = mt_q;
   assign bus.loadneg = loadneg_q;
   assign bus.running = running_q;
   assign bus.alarm   = alarm_q;
   assign bus.err     = err_q;

endmodule

// File: tb/tb_timer_ctrl_mmss.sv
// Table-driven scoreboard bench for timer_ctrl_mmss; the bench plays the role of the
// four BCD counters by driving the zero flags per vector.
module tb_timer_ctrl_mmss;

   localparam logic [2:0] N = 3'd0, DG = 3'd1, LD = 3'd2, ST = 3'd3, SP = 3'd4, LS = 3'd5;

   typedef struct packed {
      logic [2:0]  cmd;
      logic [3:0]  kd;
      logic        tk;
      logic [3:0]  z;
      logic        en;
      logic [15:0] data;
      logic        ln;
      logic        run;
      logic        al;
      logic        err;
   } vec_t;

   logic clk = 1'b0;
   logic clear;
   int   checks = 0;
   int   failures = 0;
   int   mon_idx = 0;
   vec_t tbl[$];
   vec_t exp_q[$];

   timer_ctrl_mmss_if bus ();

   timer_ctrl_mmss #(.ALARM_SECS(10)) dut (
      .clk   (clk),
      .clear (clear),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s[%0d] got=%0h want=%0h", nm, idx, act, exp);
      end
   endtask

   task automatic add(input logic [2:0] cmd, input logic [3:0] kd, input logic tk,
                      input logic [3:0] z, input logic en, input logic [15:0] d,
                      input logic ln, input logic run, input logic al, input logic err);
      vec_t v;
      v = '{cmd: cmd, kd: kd, tk: tk, z: z, en: en, data: d, ln: ln, run: run, al: al, err: err};
      tbl.push_back(v);
   endtask

   task automatic drive(input vec_t v);
      bus.digit_valid = (v.cmd == DG);
      bus.load_btn    = (v.cmd == LD) || (v.cmd == LS);
      bus.start       = (v.cmd == ST) || (v.cmd == LS);
      bus.stop        = (v.cmd == SP);
      bus.key_digit   = v.kd;
      bus.tick_1hz    = v.tk;
      {bus.zero_mt, bus.zero_mu, bus.zero_st, bus.zero_su} = v.z;
   endtask

   function automatic logic [15:0] dout();
      return {bus.data_mt, bus.data_mu, bus.data_st, bus.data_su};
   endfunction

   // Registered outputs are compared one step after the edge that consumed the vector.
   always @(posedge clk) begin
      vec_t e;
      #1;
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         chk("data",    mon_idx, 32'(dout()),      32'(e.data));
         chk("loadneg", mon_idx, 32'(bus.loadneg), 32'(e.ln));
         chk("running", mon_idx, 32'(bus.running), 32'(e.run));
         chk("alarm",   mon_idx, 32'(bus.alarm),   32'(e.al));
         chk("err",     mon_idx, 32'(bus.err),     32'(e.err));
         mon_idx++;
      end
   end

   initial begin
      vec_t idle;
      idle = '{cmd: N, kd: 4'd0, tk: 1'b0, z: 4'hF, en: 1'b0, data: 16'h0, ln: 1'b1, run: 1'b0, al: 1'b0, err: 1'b0};

      // digit entry, bad digit, load 12:30, run, pause, resume, done, ack
      add(DG, 1, 0, 4'hF, 0, 16'h0001, 1, 0, 0, 0);
      add(DG, 2, 0, 4'hF, 0, 16'h0012, 1, 0, 0, 0);
      add(DG, 3, 0, 4'hF, 0, 16'h0123, 1, 0, 0, 0);
      add(DG, 0, 0, 4'hF, 0, 16'h1230, 1, 0, 0, 0);
      add(DG, 12, 0, 4'hF, 0, 16'h1230, 1, 0, 0, 1);
      add(N,  0, 0, 4'hF, 0, 16'h1230, 1, 0, 0, 0);
      add(LD, 0, 0, 4'hF, 0, 16'h1230, 0, 0, 0, 0);
      add(N,  0, 0, 4'h0, 0, 16'h1230, 1, 0, 0, 0);
      add(N,  0, 0, 4'h0, 0, 16'h1230, 1, 0, 0, 0);
      add(ST, 0, 0, 4'h0, 0, 16'h1230, 1, 1, 0, 0);
      add(N,  0, 1, 4'h0, 1, 16'h1230, 1, 1, 0, 0);
      add(N,  0, 0, 4'h0, 0, 16'h1230, 1, 1, 0, 0);
      add(N,  0, 1, 4'h0, 1, 16'h1230, 1, 1, 0, 0);
      add(SP, 0, 0, 4'h0, 0, 16'h1230, 1, 0, 0, 0);
      for (int i = 0; i < 5; i++) add(N, 0, 1, 4'h0, 0, 16'h1230, 1, 0, 0, 0);
      add(ST, 0, 0, 4'h0, 0, 16'h1230, 1, 1, 0, 0);
      add(N,  0, 1, 4'h0, 1, 16'h1230, 1, 1, 0, 0);
      add(N,  0, 0, 4'hF, 0, 16'h1230, 1, 0, 1, 0);
      add(N,  0, 1, 4'hF, 0, 16'h1230, 1, 0, 1, 0);
      add(SP, 0, 0, 4'hF, 0, 16'h1230, 1, 0, 0, 0);
      add(ST, 0, 0, 4'hF, 0, 16'h1230, 1, 0, 0, 0);
      // 00:03, load+start together, 3 ticks, no wrap, full alarm timeout
      add(DG, 0, 0, 4'hF, 0, 16'h2300, 1, 0, 0, 0);
      add(DG, 0, 0, 4'hF, 0, 16'h3000, 1, 0, 0, 0);
      add(DG, 0, 0, 4'hF, 0, 16'h0000, 1, 0, 0, 0);
      add(DG, 3, 0, 4'hF, 0, 16'h0003, 1, 0, 0, 0);
      add(LS, 0, 0, 4'hF, 0, 16'h0003, 0, 0, 0, 0);
      add(N,  0, 0, 4'h0, 0, 16'h0003, 1, 0, 0, 0);
      add(ST, 0, 0, 4'h0, 0, 16'h0003, 1, 1, 0, 0);
      for (int i = 0; i < 3; i++) add(N, 0, 1, 4'h0, 1, 16'h0003, 1, 1, 0, 0);
      add(N,  0, 1, 4'hF, 0, 16'h0003, 1, 0, 1, 0);
      for (int i = 1; i <= 10; i++) add(N, 0, 1, 4'hF, 0, 16'h0003, 1, 0, logic'(i < 10), 0);
      add(ST, 0, 0, 4'hF, 0, 16'h0003, 1, 0, 0, 0);
      // 01:70 rejected, then 00:00 load and rejected start
      add(DG, 0, 0, 4'hF, 0, 16'h0030, 1, 0, 0, 0);
      add(DG, 1, 0, 4'hF, 0, 16'h0301, 1, 0, 0, 0);
      add(DG, 7, 0, 4'hF, 0, 16'h3017, 1, 0, 0, 0);
      add(DG, 0, 0, 4'hF, 0, 16'h0170, 1, 0, 0, 0);
      add(LD, 0, 0, 4'hF, 0, 16'h0170, 1, 0, 0, 1);
      add(N,  0, 0, 4'hF, 0, 16'h0170, 1, 0, 0, 0);
      add(DG, 0, 0, 4'hF, 0, 16'h1700, 1, 0, 0, 0);
      add(DG, 0, 0, 4'hF, 0, 16'h7000, 1, 0, 0, 0);
      add(DG, 0, 0, 4'hF, 0, 16'h0000, 1, 0, 0, 0);
      add(DG, 0, 0, 4'hF, 0, 16'h0000, 1, 0, 0, 0);
      add(LD, 0, 0, 4'hF, 0, 16'h0000, 0, 0, 0, 0);
      add(N,  0, 0, 4'hF, 0, 16'h0000, 1, 0, 0, 0);
      add(ST, 0, 0, 4'hF, 0, 16'h0000, 1, 0, 0, 1);
      add(N,  0, 0, 4'hF, 0, 16'h0000, 1, 0, 0, 0);
      // 00:01, stop acknowledges alarm after 2 ticks
      add(DG, 1, 0, 4'hF, 0, 16'h0001, 1, 0, 0, 0);
      add(LD, 0, 0, 4'hF, 0, 16'h0001, 0, 0, 0, 0);
      add(N,  0, 0, 4'h0, 0, 16'h0001, 1, 0, 0, 0);
      add(ST, 0, 0, 4'h0, 0, 16'h0001, 1, 1, 0, 0);
      add(N,  0, 1, 4'h0, 1, 16'h0001, 1, 1, 0, 0);
      add(N,  0, 0, 4'hF, 0, 16'h0001, 1, 0, 1, 0);
      add(N,  0, 1, 4'hF, 0, 16'h0001, 1, 0, 1, 0);
      add(N,  0, 1, 4'hF, 0, 16'h0001, 1, 0, 1, 0);
      add(SP, 0, 0, 4'hF, 0, 16'h0001, 1, 0, 0, 0);
      add(ST, 0, 0, 4'hF, 0, 16'h0001, 1, 0, 0, 0);
      // 05:59 boundary load; digit and load ignored while running
      add(DG, 0, 0, 4'hF, 0, 16'h0010, 1, 0, 0, 0);
      add(DG, 5, 0, 4'hF, 0, 16'h0105, 1, 0, 0, 0);
      add(DG, 5, 0, 4'hF, 0, 16'h1055, 1, 0, 0, 0);
      add(DG, 9, 0, 4'hF, 0, 16'h0559, 1, 0, 0, 0);
      add(LD, 0, 0, 4'hF, 0, 16'h0559, 0, 0, 0, 0);
      add(N,  0, 0, 4'h0, 0, 16'h0559, 1, 0, 0, 0);
      add(ST, 0, 0, 4'h0, 0, 16'h0559, 1, 1, 0, 0);
      add(DG, 4, 0, 4'h0, 0, 16'h0559, 1, 1, 0, 0);
      add(LD, 0, 0, 4'h0, 0, 16'h0559, 1, 1, 0, 0);

      clear = 1'b1;
      drive(idle);
      bus.tick_1hz = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_data",    0, 32'(dout()),      32'h0);
      chk("rst_loadneg", 0, 32'(bus.loadneg), 32'h1);
      chk("rst_running", 0, 32'(bus.running), 32'h0);
      chk("rst_alarm",   0, 32'(bus.alarm),   32'h0);
      chk("rst_err",     0, 32'(bus.err),     32'h0);
      chk("rst_en_su",   0, 32'(bus.en_su),   32'h0);
      clear = 1'b0;
      bus.tick_1hz = 1'b0;

      foreach (tbl[i]) begin
         @(negedge clk);
         drive(tbl[i]);
         #1;
         chk("en_su", i, 32'(bus.en_su), 32'(tbl[i].en));
         exp_q.push_back(tbl[i]);
      end
      @(negedge clk);
      drive(idle);
      {bus.zero_mt, bus.zero_mu, bus.zero_st, bus.zero_su} = 4'h0;
      @(posedge clk);
      #2;

      // still in RUN with 05:59 loaded; clear lands between edges
      @(negedge clk);
      bus.tick_1hz = 1'b1;
      #1;
      chk("pre_clr_en_su", 0, 32'(bus.en_su), 32'h1);
      #1;
      clear = 1'b1;
      #1;
      chk("clr_running", 0, 32'(bus.running), 32'h0);
      chk("clr_alarm",   0, 32'(bus.alarm),   32'h0);
      chk("clr_en_su",   0, 32'(bus.en_su),   32'h0);
      chk("clr_data",    0, 32'(dout()),      32'h0);
      chk("clr_loadneg", 0, 32'(bus.loadneg), 32'h1);
      @(negedge clk);
      clear = 1'b0;
      bus.tick_1hz = 1'b0;
      {bus.zero_mt, bus.zero_mu, bus.zero_st, bus.zero_su} = 4'hF;

      // clear during the loadneg-low cycle releases the strobe at once
      @(negedge clk);
      bus.load_btn = 1'b1;
      @(posedge clk);
      #1;
      bus.load_btn = 1'b0;
      chk("ld_low", 0, 32'(bus.loadneg), 32'h0);
      #1;
      clear = 1'b1;
      #1;
      chk("ld_clr", 0, 32'(bus.loadneg), 32'h1);
      @(negedge clk);
      clear = 1'b0;
      repeat (2) @(posedge clk);
      #2;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
